// File: rtl/alu_issue.sv
// alu_issue: 4-entry request FIFO issuing to an external ALU, registered result.
// Define ALU_ISSUE_ACC_EN to enable the accumulator operand path (in_use_acc/acc).
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_use_acc,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_zero,
  output logic [31:0] acc,
  output logic [2:0]  count
);

  logic [2:0]  op_q [4];
  logic [2:0]  op_d [4];
  logic [31:0] a_q [4];
  logic [31:0] a_d [4];
  logic [31:0] b_q [4];
  logic [31:0] b_d [4];
`ifdef ALU_ISSUE_ACC_EN
  logic        ua_q [4];
  logic        ua_d [4];
`else
  logic        unused_use_acc;
  assign unused_use_acc = in_use_acc;
`endif

  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic        out_zero_q, out_zero_d;
  logic [31:0] out_y_q, out_y_d;
  logic [31:0] acc_q, acc_d;
  logic        push, issue, empty;

  // Handshake decisions use registered occupancy only.
  assign empty    = (count_q == 3'd0);
  assign in_ready = (count_q != 3'd4);
  assign push     = in_valid && in_ready;
  assign issue    = !empty && (!out_valid_q || out_ready);

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_zero  = out_zero_q;
  assign acc       = acc_q;
  assign count     = count_q;

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (!empty) begin
      alu_op = op_q[rd_ptr_q];
      alu_b  = b_q[rd_ptr_q];
`ifdef ALU_ISSUE_ACC_EN
      alu_a  = ua_q[rd_ptr_q] ? acc_q : a_q[rd_ptr_q];
`else
      alu_a  = a_q[rd_ptr_q];
`endif
    end
  end

  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
`ifdef ALU_ISSUE_ACC_EN
    ua_d        = ua_q;
`endif
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_zero_d  = out_zero_q;
    acc_d       = acc_q;

    if (push) begin
      op_d[wr_ptr_q] = in_op;
      a_d[wr_ptr_q]  = in_a;
      b_d[wr_ptr_q]  = in_b;
`ifdef ALU_ISSUE_ACC_EN
      ua_d[wr_ptr_q] = in_use_acc;
`endif
      wr_ptr_d = wr_ptr_q + 2'd1;
    end

    if (issue) begin
      rd_ptr_d    = rd_ptr_q + 2'd1;
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      out_zero_d  = (alu_y == 32'd0);
`ifdef ALU_ISSUE_ACC_EN
      acc_d       = alu_y;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case ({push, issue})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        op_q[i] <= '0;
        a_q[i]  <= '0;
        b_q[i]  <= '0;
`ifdef ALU_ISSUE_ACC_EN
        ua_q[i] <= 1'b0;
`endif
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_zero_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef ALU_ISSUE_ACC_EN
      ua_q        <= ua_d;
`endif
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_zero_q  <= out_zero_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: external ALU model, directed scenarios,
// randomized traffic against a queue-based result model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_use_acc;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_zero;
  logic [31:0] acc;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  bit          m_ov;
  logic [31:0] m_y;
  logic [31:0] m_acc;
  logic [31:0] chain;
  logic [31:0] full_res [5];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .acc(acc), .count(count)
  );

  function automatic logic [31:0] f(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a + 32'd1;
      3'd6:    return a - 32'd1;
      default: return b;
    endcase
  endfunction

  always_comb alu_y = f(alu_op, alu_a, alu_b);

  task automatic model_clear();
    mq.delete();
    m_ov  = 0;
    m_y   = '0;
    m_acc = '0;
    chain = '0;
  endtask

  // Advance one clock, updating the transaction-level model from the
  // inputs present just before the edge. Returns at edge + 1.
  task automatic cycle();
    bit          pop, push;
    logic [31:0] opa, r;
    pop  = (mq.size() != 0) && (!m_ov || out_ready);
    push = in_valid && (mq.size() < 4);
    r    = '0;
    if (push) begin
`ifdef ALU_ISSUE_ACC_EN
      opa = in_use_acc ? chain : in_a;
`else
      opa = in_a;
`endif
      r     = f(in_op, opa, in_b);
      chain = r;
    end
    if (pop) begin
      m_y  = mq.pop_front();
      m_ov = 1;
`ifdef ALU_ISSUE_ACC_EN
      m_acc = m_y;
`endif
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (push) mq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset      = 1;
    in_valid   = 0;
    in_op      = '0;
    in_a       = '0;
    in_b       = '0;
    in_use_acc = 0;
    out_ready  = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt_ov got=%0d/%0b exp=0/0", count, out_valid);
    end
    checks++;
    if (out_y !== 32'd0 || out_zero !== 1'b0 || acc !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs got=%0h/%0b/%0h exp=0/0/0",
               out_y, out_zero, acc);
    end
    cycle();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%0b exp=1", in_ready);
    end
    checks++;
    if (alu_op !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      failures++;
      $display("FAIL empty_alu got=%0h/%0h/%0h exp=0/0/0",
               alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_acc;
`ifdef ALU_ISSUE_ACC_EN
    exp_acc = 32'd12;
`else
    exp_acc = 32'd0;
`endif
    out_ready  = 1;
    in_valid   = 1;
    in_op      = 3'b001;
    in_a       = 32'd5;
    in_b       = 32'd7;
    in_use_acc = 0;
    cycle();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd1) begin
      failures++;
      $display("FAIL basic_edge1 got=%0b/%0d exp=0/1", out_valid, count);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 32'd12 || out_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got=%0b/%0d/%0b exp=1/12/0",
               out_valid, out_y, out_zero);
    end
    checks++;
    if (acc !== exp_acc) begin
      failures++;
      $display("FAIL basic_acc got=%0d exp=%0d", acc, exp_acc);
    end
    idle(2);
  endtask

  task automatic test_zero_wrap();
    out_ready  = 1;
    in_valid   = 1;
    in_op      = 3'b010;
    in_a       = 32'd3;
    in_b       = 32'd3;
    in_use_acc = 0;
    cycle();
    in_valid = 0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_y !== 32'd0 || out_zero !== 1'b1) begin
      failures++;
      $display("FAIL zero_flag got=%0b/%0h/%0b exp=1/0/1",
               out_valid, out_y, out_zero);
    end
    in_valid = 1;
    in_op    = 3'b110;
    in_a     = 32'd0;
    in_b     = $urandom;
    cycle();
    in_valid = 0;
    cycle();
    checks++;
    if (out_y !== 32'hFFFF_FFFF || out_zero !== 1'b0) begin
      failures++;
      $display("FAIL dec_wrap got=%0h/%0b exp=ffffffff/0", out_y, out_zero);
    end
    idle(2);
  endtask

  task automatic test_full();
    out_ready = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid   = 1;
      in_op      = 3'b001;
      in_a       = 32'(k * 100 + 1);
      in_b       = 32'(k);
      in_use_acc = 0;
      if (k < 5) full_res[k] = 32'(k * 101 + 1);
      checks++;
      if (in_ready !== (k < 5)) begin
        failures++;
        $display("FAIL full_ready k=%0d got=%0b exp=%0b", k, in_ready, k < 5);
      end
      cycle();
      if (k >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== full_res[0]) begin
          failures++;
          $display("FAIL full_hold k=%0d got=%0b/%0d exp=1/%0d",
                   k, out_valid, out_y, full_res[0]);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_count got=%0d/%0b exp=4/0", count, in_ready);
    end
  endtask

  task automatic test_drain();
    out_ready = 1;
    for (int k = 1; k < 5; k++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_y !== full_res[k] ||
          count !== 3'(4 - k)) begin
        failures++;
        $display("FAIL drain k=%0d got=%0b/%0d/%0d exp=1/%0d/%0d",
                 k, out_valid, out_y, count, full_res[k], 4 - k);
      end
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL drain_end got=%0b/%0d exp=0/0", out_valid, count);
    end
  endtask

  task automatic test_acc_chain();
    logic [31:0] ea [3];
    logic [31:0] av [3];
`ifdef ALU_ISSUE_ACC_EN
    ea = '{32'd11, 32'd12, 32'd13};
`else
    ea = '{32'd11, 32'd21, 32'd31};
`endif
    av = '{32'd10, 32'd20, 32'd30};
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        in_valid   = 1;
        in_op      = 3'b101;
        in_a       = av[k];
        in_b       = $urandom;
        in_use_acc = (k != 0);
      end else begin
        in_valid = 0;
      end
      cycle();
      if (k >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== ea[k-1]) begin
          failures++;
          $display("FAIL acc_chain k=%0d got=%0b/%0d exp=1/%0d",
                   k, out_valid, out_y, ea[k-1]);
        end
      end
    end
    in_use_acc = 0;
    idle(2);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_op      = 3'($urandom_range(0, 7));
      in_a       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom;
      in_b       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom;
      in_use_acc = $urandom_range(0, 1);
      cycle();
      checks++;
      if (out_valid !== m_ov || count !== 3'(mq.size()) ||
          in_ready !== (mq.size() < 4) || acc !== m_acc ||
          (m_ov && (out_y !== m_y || out_zero !== (m_y == 32'd0)))) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random i=%0d got=%0b/%0d/%0h/%0b/%0h exp=%0b/%0d/%0h/%0b/%0h",
                   i, out_valid, count, out_y, out_zero, acc,
                   m_ov, mq.size(), m_y, m_y == 32'd0, m_acc);
      end
      if (mq.size() == 0) begin
        checks++;
        if (alu_op !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
          failures++;
          $display("FAIL random_alu_idle i=%0d got=%0h/%0h/%0h exp=0/0/0",
                   i, alu_op, alu_a, alu_b);
        end
      end
    end
    idle(6);
  endtask

  task automatic test_mid_reset();
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid   = 1;
      in_op      = 3'b001;
      in_a       = $urandom;
      in_b       = 32'd1;
      in_use_acc = 0;
      cycle();
    end
    in_valid = 0;
    checks++;
    if (count !== 3'd3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup got=%0d/%0b exp=3/1", count, out_valid);
    end
    #2;
    reset = 1;
    model_clear();
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 32'd0) begin
      failures++;
      $display("FAIL mid_async got=%0d/%0b/%0h exp=0/0/0",
               count, out_valid, acc);
    end
    @(posedge clk);
    #1;
    reset     = 0;
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_after k=%0d got=%0b/%0d/%0b exp=0/0/1",
                 k, out_valid, count, in_ready);
      end
    end
  endtask

  initial begin
    reset      = 1;
    in_valid   = 0;
    in_op      = '0;
    in_a       = '0;
    in_b       = '0;
    in_use_acc = 0;
    out_ready  = 1;
    model_clear();
    test_reset();
    test_basic();
    test_zero_wrap();
    test_full();
    test_drain();
    test_acc_chain();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
